anim_scheduler: RTL

Sequencing controller that sits between the push-button `go` input and the per-animation row sources feeding `spi_lcd`. It selects which animation drives the LCD row bus and which frame of that animation is shown. Animation switches are deferred to LCD frame boundaries so a frame is never torn, and frame advance is paced by a count of completed LCD frames.

---
 rtl/anim_pkg.sv | 16 +
 rtl/frame_pacer.sv | 47 ++++
 rtl/anim_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/anim_pkg.sv
// Shared types and constants for the animation sequencing slice.
package anim_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PEND = 2'd1,
        S_SWAP = 2'd2
    } state_t;

    localparam int ANIM_IDLE  = 0;
    localparam int ANIM_SMILE = 1;

    // lcd_frame_done from spi_lcd is a single-cycle strobe.
    localparam int LCD_DONE_PULSE_W = 1;

endpackage

// File: rtl/frame_pacer.sv
// Holds each animation frame for HOLD_FRAMES LCD frames, then advances frame_idx with wrap.
// Synchronous clear restarts the animation at frame 0 with an empty hold count.
module frame_pacer #(
    parameter int FRAMES_PER_ANIM = 4,
    parameter int HOLD_FRAMES     = 8,
    localparam int FW = $clog2(FRAMES_PER_ANIM),
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          tick_i,
    output logic [FW-1:0] frame_idx_o
);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [FW-1:0] frame_q, frame_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        frame_d    = frame_q;
        if (clr_i) begin
            hold_cnt_d = '0;
            frame_d    = '0;
        end else if (tick_i) begin
            if (hold_cnt_q == HW'(HOLD_FRAMES - 1)) begin
                hold_cnt_d = '0;
                frame_d    = (frame_q == FW'(FRAMES_PER_ANIM - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            frame_q    <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            frame_q    <= frame_d;
        end
    end

    assign frame_idx_o = frame_q;

endmodule

// File: rtl/anim_scheduler.sv
// Selects the animation and frame shown on the LCD; go presses queue a switch that is
// applied only at an LCD frame boundary, followed by a one-cycle lcd_hold stall.
module anim_scheduler
    import anim_pkg::*;
#(
    parameter int NUM_ANIM        = 2,
    parameter int FRAMES_PER_ANIM = 4,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               go,
    input  logic                               lcd_frame_done,
    output logic [$clog2(NUM_ANIM)-1:0]        anim_sel,
    output logic [$clog2(FRAMES_PER_ANIM)-1:0] frame_idx,
    output logic                               switch_pending,
    output logic                               lcd_hold
);

    localparam int AW = $clog2(NUM_ANIM);

    state_t        state_q, state_d;
    logic [AW-1:0] anim_q, anim_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic          go_q;
    logic          go_rise;
    logic          pend_q, hold_q;
    logic          swap_now;
    logic          adv;

    function automatic logic [AW-1:0] next_anim(input logic [AW-1:0] a);
        return (a == AW'(NUM_ANIM - 1)) ? '0 : a + 1'b1;
    endfunction

    assign go_rise = go & ~go_q;

    always_comb begin
        state_d  = state_q;
        anim_d   = anim_q;
        tgt_d    = tgt_q;
        swap_now = 1'b0;
        adv      = 1'b0;
        case (state_q)
            S_RUN: begin
                adv = lcd_frame_done;
                if (go_rise) begin
                    tgt_d   = next_anim(anim_q);
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                // A press in the same cycle as the boundary still counts toward the target.
                if (go_rise) tgt_d = next_anim(tgt_q);
                if (lcd_frame_done) begin
                    anim_d   = tgt_d;
                    swap_now = 1'b1;
                    state_d  = S_SWAP;
                end
            end
            S_SWAP: begin
                state_d = S_RUN;
                if (go_rise) begin
                    tgt_d   = next_anim(anim_q);
                    state_d = S_PEND;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            anim_q  <= '0;
            tgt_q   <= '0;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            tgt_q   <= tgt_d;
            go_q    <= go;
            pend_q  <= (state_d == S_PEND);
            hold_q  <= (state_d == S_SWAP);
        end
    end

    frame_pacer #(
        .FRAMES_PER_ANIM (FRAMES_PER_ANIM),
        .HOLD_FRAMES     (HOLD_FRAMES)
    ) u_pacer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (swap_now),
        .tick_i      (adv),
        .frame_idx_o (frame_idx)
    );

    assign anim_sel       = anim_q;
    assign switch_pending = pend_q;
    assign lcd_hold       = hold_q;

endmodule
